fifo_ext: RTL and testbench



---
 rtl/fifo_ext_pkg.sv | 25 ++
 rtl/fifo_ext_mem.sv | 32 +++
 rtl/fifo_ext.sv | 151 +++++++++++++++
 tb/tb_fifo_ext.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ext_pkg
// Purpose  : Width helpers and parameter sanity check shared by the fifo_ext files.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_ext_pkg;

    // Occupancy counter must be able to hold DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit levels_ok(input int depth, input int afull, input int aempty);
        return (afull >= 0) && (afull <= depth) && (aempty >= 0) && (aempty < depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ext_mem.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ext_mem
// Purpose  : Simple dual-port storage, synchronous write, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ext_mem
    import fifo_ext_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [ptr_w(DEPTH)-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [ptr_w(DEPTH)-1:0]     raddr,
    output logic [DATA_WIDTH-1:0]       rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fifo_ext.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ext
// Purpose  : Single-clock FIFO with arbitrary depth, fill count, almost flags,
//            optional FWFT read, flush and sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ext
    import fifo_ext_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int FWFT       = 0,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        clr_err,
    input  logic                        wren,
    input  logic [DATA_WIDTH-1:0]       i_data,
    input  logic                        rden,
    output logic [DATA_WIDTH-1:0]       o_data,
    output logic                        o_valid,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [cnt_w(DEPTH)-1:0]     count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int c_cnt_w = cnt_w(DEPTH);
    localparam int c_ptr_w = ptr_w(DEPTH);

    localparam logic [c_cnt_w-1:0] c_depth      = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_afull_lvl  = c_cnt_w'(AFULL_LVL);
    localparam logic [c_cnt_w-1:0] c_aempty_lvl = c_cnt_w'(AEMPTY_LVL);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_last   = c_ptr_w'(DEPTH - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_one    = c_ptr_w'(1);

    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_rdata;

    generate
        if (!levels_ok(DEPTH, AFULL_LVL, AEMPTY_LVL)) begin : g_bad_levels
            $error("fifo_ext: AFULL_LVL must be <= DEPTH and AEMPTY_LVL < DEPTH");
        end
    endgenerate

    assign w_full   = (r_count == c_depth);
    assign w_empty  = (r_count == '0);
    assign w_rd_acc = rden & ~w_empty;
    assign w_wr_acc = wren & (~w_full | w_rd_acc);

    // Flush blocks all accepts; the raw accept terms still drive the error flags.
    assign w_push = w_wr_acc & ~flush;
    assign w_pop  = w_rd_acc & ~flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags: a new event in the same cycle as clr_err wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (~flush & wren & ~w_wr_acc) | (r_overflow  & ~clr_err);
            r_underflow <= (~flush & rden & w_empty)   | (r_underflow & ~clr_err);
        end
    end

    fifo_ext_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (i_data),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign o_data  = w_rdata;
            assign o_valid = ~w_empty;
        end else begin : g_regout
            logic [DATA_WIDTH-1:0] r_data;
            logic                  r_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_pop;
                    if (w_pop) begin
                        r_data <= w_rdata;
                    end
                end
            end

            assign o_data  = r_data;
            assign o_valid = r_valid;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_afull_lvl);
    assign almost_empty = (r_count <= c_aempty_lvl);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_ext
// Purpose  : Directed and random checks of fifo_ext against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_ext;

    localparam int DW    = 8;
    localparam int DEPTH = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          clr_err = 1'b0;
    logic          wren = 1'b0;
    logic          rden = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic [DW-1:0] o_data;
    logic          o_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0]    count;

    logic          fw_wren = 1'b0;
    logic          fw_rden = 1'b0;
    logic [DW-1:0] fw_i_data = '0;
    logic [DW-1:0] fw_o_data;
    logic          fw_o_valid, fw_full, fw_empty, fw_afull, fw_aempty, fw_ovf, fw_unf;
    logic [2:0]    fw_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq[$];
    logic          m_ov, m_un;
    logic [DW-1:0] m_last;

    always #5 clk = ~clk;

    fifo_ext #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err),
        .wren(wren), .i_data(i_data), .rden(rden),
        .o_data(o_data), .o_valid(o_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_ext #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fw (
        .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err),
        .wren(fw_wren), .i_data(fw_i_data), .rden(fw_rden),
        .o_data(fw_o_data), .o_valid(fw_o_valid), .full(fw_full), .empty(fw_empty),
        .almost_full(fw_afull), .almost_empty(fw_aempty), .count(fw_count),
        .overflow(fw_ovf), .underflow(fw_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"},     32'(count),        32'(n));
        chk({tag, ".full"},      32'(full),         32'(n == DEPTH));
        chk({tag, ".empty"},     32'(empty),        32'(n == 0));
        chk({tag, ".afull"},     32'(almost_full),  32'(n >= DEPTH - 2));
        chk({tag, ".aempty"},    32'(almost_empty), 32'(n <= 2));
        chk({tag, ".overflow"},  32'(overflow),     32'(m_ov));
        chk({tag, ".underflow"}, 32'(underflow),    32'(m_un));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        m_last = '0;
        check_status(tag);
        chk({tag, ".o_valid"}, 32'(o_valid), 32'd0);
        chk({tag, ".o_data"},  32'(o_data),  32'd0);
    endtask

    // One clock of stimulus on the registered-read FIFO, then compare against the model.
    task automatic cycle(input string tag, input logic w, input logic [DW-1:0] d,
                         input logic r, input logic c, input logic f);
        int   n;
        logic racc, wok, ov_set, un_set;
        n      = mq.size();
        racc   = r && (n > 0) && !f;
        wok    = (n < DEPTH) || (r && n > 0);
        ov_set = !f && w && !wok;
        un_set = !f && r && (n == 0);
        wren = w; i_data = d; rden = r; clr_err = c; flush = f;
        @(posedge clk); #1;
        wren = 1'b0; rden = 1'b0; clr_err = 1'b0; flush = 1'b0;
        if (f) begin
            mq.delete();
        end else begin
            if (racc) m_last = mq.pop_front();
            if (w && wok) mq.push_back(d);
        end
        m_ov = ov_set ? 1'b1 : (c ? 1'b0 : m_ov);
        m_un = un_set ? 1'b1 : (c ? 1'b0 : m_un);
        chk({tag, ".o_valid"}, 32'(o_valid), 32'(racc));
        chk({tag, ".o_data"},  32'(o_data),  32'(m_last));
        check_status(tag);
    endtask

    initial begin
        m_ov = 1'b0;
        m_un = 1'b0;
        m_last = '0;
        do_reset("reset");
        chk("fw_reset.o_valid", 32'(fw_o_valid), 32'd0);
        chk("fw_reset.empty",   32'(fw_empty),   32'd1);

        // FWFT: simultaneous read/write on empty
        fw_wren = 1'b1; fw_rden = 1'b1; fw_i_data = 8'h33;
        @(posedge clk); #1;
        fw_wren = 1'b0; fw_rden = 1'b0;
        chk("fw_rw_empty.underflow", 32'(fw_unf),     32'd1);
        chk("fw_rw_empty.count",     32'(fw_count),   32'd1);
        chk("fw_rw_empty.o_data",    32'(fw_o_data),  32'h33);
        chk("fw_rw_empty.o_valid",   32'(fw_o_valid), 32'd1);
        fw_rden = 1'b1;
        @(posedge clk); #1;
        fw_rden = 1'b0;
        chk("fw_pop.empty",   32'(fw_empty),   32'd1);
        chk("fw_pop.o_valid", 32'(fw_o_valid), 32'd0);

        // Fill, overflow, drain
        for (int i = 1; i <= DEPTH; i++) cycle("fill", 1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        cycle("overflow_wr", 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle("clr_err", 1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Random interleaving across pointer wraps
        for (int i = 0; i < 100; i++)
            cycle("random", 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        while (mq.size() > 0) cycle("rand_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle("clr_err2", 1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Full with simultaneous read and write
        for (int i = 0; i < DEPTH; i++) cycle("fill2", 1'b1, DW'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        cycle("full_rw", 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle("drain2", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Empty with simultaneous read and write, then a bare read on empty
        cycle("empty_rw", 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        cycle("empty_rw_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle("empty_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Flush with a write pending; error flags must survive
        for (int i = 0; i < 4; i++) cycle("fill4", 1'b1, DW'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        cycle("flush", 1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        cycle("clr_err3", 1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Reset mid-stream with o_valid high
        for (int i = 0; i < 4; i++) cycle("pre_rst", 1'b1, DW'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        cycle("pre_rst_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        do_reset("mid_reset");
        cycle("post_rst_wr", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        cycle("post_rst_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
